// File: rtl/special_cmd_pkg.sv
// Shared types and constants for the special-key / OSD command sequencer.
package special_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RST_ASSERT  = 3'd1,
        ST_RST_RELEASE = 3'd2,
        ST_HOLD_REQ    = 3'd3,
        ST_HELD        = 3'd4,
        ST_UNHOLD      = 3'd5
    } state_t;

    // Bit positions of the OSD command levels
    localparam int OSD_HOLD   = 0;
    localparam int OSD_BLKSBR = 1;
    localparam int OSD_RESET  = 2;

    // Tick counter width: the counter only ever holds 0 .. max(ticks)-1
    function automatic int tick_cnt_width(input int reset_ticks, input int hold_timeout);
        int m;
        m = (reset_ticks > hold_timeout) ? reset_ticks : hold_timeout;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/special_cmd_sequencer_req_edge_latch.sv
// Request level register with rising-edge detect and a pending flag.
// The first sample after reset only primes the history, so a level that is
// already high when reset releases does not count as a new request.
module req_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic clr,
    output logic pend
);

    logic req_r;
    logic armed_r;
    logic rise_s;

    assign rise_s = armed_r & req & ~req_r;

    // Track the previous request level and arm edge detection after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            req_r   <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            req_r   <= req;
            armed_r <= 1'b1;
        end
    end

    // Pending flag: a fresh edge wins over an acceptance in the same clk
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
        end else if (rise_s) begin
            pend <= 1'b1;
        end else if (clr) begin
            pend <= 1'b0;
        end else begin
            pend <= pend;
        end
    end

endmodule

// File: rtl/special_cmd_sequencer.sv
// Special-key / OSD command sequencer: BLK+SBR reset with ROM disable,
// plain reset, and bus HOLD toggle, executed one at a time by priority.
// Optional build macro SPECIALKEYS_ROM_RESTORE_EN: a plain reset action
// re-enables the boot ROM on entry to the reset window.
module special_cmd_sequencer
    import special_cmd_pkg::*;
#(
    parameter int RESET_TICKS  = 16,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_ce,
    input  logic       key_blksbr,
    input  logic       key_reset,
    input  logic       key_hold,
    input  logic [7:0] osd_command,
    input  logic       hlda,
    output logic       o_cpu_reset,
    output logic       o_disable_rom,
    output logic       o_hold_req,
    output logic       o_osd,
    output logic       o_busy,
    output logic       o_hold_timeout
);

    localparam int CW = tick_cnt_width(RESET_TICKS, HOLD_TIMEOUT);
    localparam logic [CW-1:0] RST_LAST  = CW'(RESET_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t        state_r;
    logic [CW-1:0] cnt_r;

    logic req_blksbr_s, req_reset_s, req_hold_s;
    logic pend_blksbr_s, pend_reset_s, pend_hold_s;
    logic clr_blksbr_s, clr_reset_s, clr_hold_s;
    logic accept_s;
    logic unused_osd_s;

    assign req_blksbr_s = key_blksbr | osd_command[OSD_BLKSBR];
    assign req_reset_s  = key_reset  | osd_command[OSD_RESET];
    assign req_hold_s   = key_hold   | osd_command[OSD_HOLD];
    assign unused_osd_s = ^osd_command[7:3];

    req_edge_latch u_blksbr (.clk(clk), .reset(reset), .req(req_blksbr_s), .clr(clr_blksbr_s), .pend(pend_blksbr_s));
    req_edge_latch u_reset  (.clk(clk), .reset(reset), .req(req_reset_s),  .clr(clr_reset_s),  .pend(pend_reset_s));
    req_edge_latch u_hold   (.clk(clk), .reset(reset), .req(req_hold_s),   .clr(clr_hold_s),   .pend(pend_hold_s));

    // Acceptance strobes: mirror the FSM's priority decisions in IDLE/HELD;
    // a hold toggle requested during a reset window is dropped on release
    always_comb begin
        accept_s     = (state_r == ST_IDLE) || (state_r == ST_HELD);
        clr_blksbr_s = accept_s & pend_blksbr_s;
        clr_reset_s  = accept_s & ~pend_blksbr_s & pend_reset_s;
        clr_hold_s   = (accept_s & ~pend_blksbr_s & ~pend_reset_s & pend_hold_s)
                     | (state_r == ST_RST_RELEASE);
    end

    // Main sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {CW{1'b0}};
            o_cpu_reset    <= 1'b0;
            o_disable_rom  <= 1'b0;
            o_hold_req     <= 1'b0;
            o_osd          <= 1'b0;
            o_busy         <= 1'b0;
            o_hold_timeout <= 1'b0;
        end else begin
            o_hold_timeout <= 1'b0;
            case (state_r)
                ST_IDLE, ST_HELD: begin
                    if (pend_blksbr_s || pend_reset_s) begin
                        state_r     <= ST_RST_ASSERT;
                        cnt_r       <= {CW{1'b0}};
                        o_cpu_reset <= 1'b1;
                        o_hold_req  <= 1'b0;
                        o_osd       <= 1'b0;
                        o_busy      <= 1'b1;
                        if (pend_blksbr_s) begin
                            o_disable_rom <= 1'b1;
                        end else begin
`ifdef SPECIALKEYS_ROM_RESTORE_EN
                            o_disable_rom <= 1'b0;
`else
                            o_disable_rom <= o_disable_rom;
`endif
                        end
                    end else if (pend_hold_s) begin
                        cnt_r  <= {CW{1'b0}};
                        o_busy <= 1'b1;
                        if (state_r == ST_IDLE) begin
                            state_r    <= ST_HOLD_REQ;
                            o_hold_req <= 1'b1;
                        end else begin
                            state_r    <= ST_UNHOLD;
                            o_hold_req <= 1'b0;
                            o_osd      <= 1'b0;
                        end
                    end else if ((state_r == ST_HELD) && !hlda) begin
                        // CPU released the bus on its own
                        state_r    <= ST_IDLE;
                        o_hold_req <= 1'b0;
                        o_osd      <= 1'b0;
                        o_busy     <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RST_ASSERT: begin
                    if (cpu_ce) begin
                        if (cnt_r == RST_LAST) begin
                            state_r     <= ST_RST_RELEASE;
                            o_cpu_reset <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_RST_RELEASE: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
                ST_HOLD_REQ: begin
                    if (hlda) begin
                        state_r <= ST_HELD;
                        o_osd   <= 1'b1;
                    end else if (cpu_ce) begin
                        if (cnt_r == HOLD_LAST) begin
                            state_r        <= ST_IDLE;
                            o_hold_req     <= 1'b0;
                            o_hold_timeout <= 1'b1;
                            o_busy         <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_UNHOLD: begin
                    if (!hlda) begin
                        state_r <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        state_r <= ST_UNHOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CW{1'b0}};
                    o_cpu_reset <= 1'b0;
                    o_hold_req  <= 1'b0;
                    o_osd       <= 1'b0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_special_cmd_sequencer.sv
// Self-checking bench for special_cmd_sequencer (RESET_TICKS=16, HOLD_TIMEOUT=8,
// cpu_ce every 4th clk). Reset windows and hold events are scoreboarded.
module tb_special_cmd_sequencer;

    localparam int RT = 16;
    localparam int HT = 8;
    localparam int EV_HELD = 1;
    localparam int EV_TMO  = 2;
    localparam int SEL_RST = 0;
    localparam int SEL_HREQ = 1;
    localparam int SEL_OSD = 2;
    localparam int SEL_BUSY = 3;
`ifdef SPECIALKEYS_ROM_RESTORE_EN
    localparam logic ROM_AFTER_F11 = 1'b0;
`else
    localparam logic ROM_AFTER_F11 = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_ce = 1'b0;
    logic       key_blksbr = 1'b0;
    logic       key_reset = 1'b0;
    logic       key_hold = 1'b0;
    logic [7:0] osd_command = 8'h00;
    logic       hlda = 1'b0;
    logic       o_cpu_reset, o_disable_rom, o_hold_req, o_osd, o_busy, o_hold_timeout;

    typedef struct {
        int   ticks;
        logic rom;
    } win_t;

    win_t exp_win[$];
    int   exp_evt[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   tmo_pulses = 0;
    logic mon_on = 1'b0;
    logic skip_win = 1'b0;

    special_cmd_sequencer #(.RESET_TICKS(RT), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .reset(reset), .cpu_ce(cpu_ce),
        .key_blksbr(key_blksbr), .key_reset(key_reset), .key_hold(key_hold),
        .osd_command(osd_command), .hlda(hlda),
        .o_cpu_reset(o_cpu_reset), .o_disable_rom(o_disable_rom),
        .o_hold_req(o_hold_req), .o_osd(o_osd), .o_busy(o_busy),
        .o_hold_timeout(o_hold_timeout)
    );

    always #5 clk = ~clk;

    // cpu_ce: one clk in four, driven just after the rising edge
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #2;
            ph = (ph + 1) % 4;
            cpu_ce = (ph == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            SEL_RST:  return o_cpu_reset;
            SEL_HREQ: return o_hold_req;
            SEL_OSD:  return o_osd;
            default:  return o_busy;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_cond(input int sel, input logic val, input int budget, input string tag);
        int i = 0;
        while (i < budget && sig_of(sel) !== val) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(sig_of(sel)), 32'(val));
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int i = 0;
        while (i < budget && exp_win.size() != 0) begin
            @(negedge clk);
            i++;
        end
        check(tag, exp_win.size(), 0);
    endtask

    task automatic push_win(input int ticks, input logic rom);
        win_t w;
        w.ticks = ticks;
        w.rom = rom;
        exp_win.push_back(w);
    endtask

    task automatic pop_evt(input int code, input string tag);
        if (exp_evt.size() == 0) check(tag, code, 0);
        else check(tag, code, exp_evt.pop_front());
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_cpu_reset"}, 32'(o_cpu_reset), 0);
        check({pfx, "_disable_rom"}, 32'(o_disable_rom), 0);
        check({pfx, "_hold_req"}, 32'(o_hold_req), 0);
        check({pfx, "_osd"}, 32'(o_osd), 0);
        check({pfx, "_busy"}, 32'(o_busy), 0);
        check({pfx, "_hold_timeout"}, 32'(o_hold_timeout), 0);
    endtask

    task automatic watch_busy(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen = seen | o_busy | o_cpu_reset | o_hold_req;
        end
    endtask

    // Output monitor: measures reset windows and hold events
    initial begin
        logic prev_rst, prev_hreq, prev_osd;
        int   win_ticks, hold_ticks;
        win_t w;
        win_ticks = 0;
        hold_ticks = 0;
        wait (mon_on);
        prev_rst = o_cpu_reset;
        prev_hreq = o_hold_req;
        prev_osd = o_osd;
        forever begin
            @(negedge clk);
            if (o_cpu_reset && cpu_ce) win_ticks++;
            if (prev_rst && !o_cpu_reset) begin
                if (skip_win) begin
                    skip_win = 1'b0;
                end else if (exp_win.size() == 0) begin
                    check("win_unexpected", 1, 0);
                end else begin
                    w = exp_win.pop_front();
                    check("win_ticks", win_ticks, w.ticks);
                    check("win_rom", 32'(o_disable_rom), 32'(w.rom));
                end
                win_ticks = 0;
            end
            if (o_hold_req && !prev_hreq) hold_ticks = 0;
            if (o_hold_req && cpu_ce) hold_ticks++;
            if (o_osd && !prev_osd) pop_evt(EV_HELD, "evt_held");
            if (o_hold_timeout) begin
                tmo_pulses++;
                pop_evt(EV_TMO, "evt_timeout");
                check("tmo_ticks", hold_ticks, HT);
            end
            prev_rst = o_cpu_reset;
            prev_hreq = o_hold_req;
            prev_osd = o_osd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic last_osd;
        int   i;

        // Reset state
        step(3);
        check_idle_outputs("rst");
        reset = 1'b0;
        mon_on = 1'b1;
        step(2);

        // F12 pulse: ROM disabled, 16-tick reset window
        push_win(RT, 1'b1);
        key_blksbr = 1'b1;
        step(1);
        key_blksbr = 1'b0;
        wait_cond(SEL_RST, 1'b1, 10, "t1_rst_rise");
        check("t1_rom_set", 32'(o_disable_rom), 1);
        wait_cond(SEL_BUSY, 1'b0, 200, "t1_idle");
        check("t1_win_done", exp_win.size(), 0);

        // Clear sticky ROM flag, then ignored OSD bits
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t2_rom_cleared", 32'(o_disable_rom), 0);
        osd_command = 8'hF8;
        step(2);
        osd_command = 8'h00;
        watch_busy(12, seen);
        check("t2_osd_hi_ignored", 32'(seen), 0);

        // F11 and OSD F12 together: BLKSBR first, then RESET
        push_win(RT, 1'b1);
        push_win(RT, ROM_AFTER_F11);
        key_reset = 1'b1;
        osd_command = 8'h02;
        step(1);
        key_reset = 1'b0;
        osd_command = 8'h00;
        wait_drain(400, "t2_drain");
        wait_cond(SEL_BUSY, 1'b0, 10, "t2_idle");
        check("t2_rom_final", 32'(o_disable_rom), 32'(ROM_AFTER_F11));

        // ScrollLock with HLDA, then release
        exp_evt.push_back(EV_HELD);
        key_hold = 1'b1;
        step(1);
        key_hold = 1'b0;
        wait_cond(SEL_HREQ, 1'b1, 10, "t3_hreq");
        step(3);
        hlda = 1'b1;
        wait_cond(SEL_OSD, 1'b1, 10, "t3_osd");
        check("t3_held_hreq", 32'(o_hold_req), 1);
        check("t3_held_busy", 32'(o_busy), 1);
        step(1);
        key_hold = 1'b1;
        step(1);
        key_hold = 1'b0;
        wait_cond(SEL_HREQ, 1'b0, 10, "t3_unhold");
        check("t3_unhold_osd", 32'(o_osd), 0);
        check("t3_unhold_busy", 32'(o_busy), 1);
        step(5);
        check("t3_wait_hlda", 32'(o_busy), 1);
        hlda = 1'b0;
        wait_cond(SEL_BUSY, 1'b0, 10, "t3_idle");

        // ScrollLock without HLDA: timeout after 8 ticks
        exp_evt.push_back(EV_TMO);
        key_hold = 1'b1;
        step(1);
        key_hold = 1'b0;
        wait_cond(SEL_HREQ, 1'b1, 10, "t4_hreq");
        wait_cond(SEL_HREQ, 1'b0, 100, "t4_hreq_drop");
        check("t4_tmo_pulse", 32'(o_hold_timeout), 1);
        check("t4_busy", 32'(o_busy), 0);
        step(1);
        check("t4_tmo_single", 32'(o_hold_timeout), 0);

        // HELD, then F11: hold and OSD drop as reset rises
        exp_evt.push_back(EV_HELD);
        key_hold = 1'b1;
        hlda = 1'b1;
        step(1);
        key_hold = 1'b0;
        wait_cond(SEL_OSD, 1'b1, 10, "t5_held");
        push_win(RT, ROM_AFTER_F11);
        key_reset = 1'b1;
        step(1);
        key_reset = 1'b0;
        seen = 1'b0;
        last_osd = o_osd;
        i = 0;
        while (i < 10 && !seen) begin
            @(negedge clk);
            if (o_cpu_reset) seen = 1'b1;
            else last_osd = o_osd;
            i++;
        end
        check("t5_rst_rise", 32'(o_cpu_reset), 1);
        check("t5_osd_before", 32'(last_osd), 1);
        check("t5_osd_drop", 32'(o_osd), 0);
        check("t5_hreq_drop", 32'(o_hold_req), 0);
        step(1);
        hlda = 1'b0;
        wait_drain(200, "t5_drain");
        wait_cond(SEL_BUSY, 1'b0, 10, "t5_idle");

        // Reset mid window, F12 held across release, hold pending discarded
        key_blksbr = 1'b1;
        step(1);
        wait_cond(SEL_RST, 1'b1, 10, "t6_rst_rise");
        key_hold = 1'b1;
        step(1);
        key_hold = 1'b0;
        step(4);
        skip_win = 1'b1;
        reset = 1'b1;
        step(1);
        check_idle_outputs("t6");
        reset = 1'b0;
        watch_busy(40, seen);
        check("t6_no_retrigger", 32'(seen), 0);
        key_blksbr = 1'b0;
        step(2);

        check("sb_windows_left", exp_win.size(), 0);
        check("sb_events_left", exp_evt.size(), 0);
        check("tmo_pulse_count", tmo_pulses, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
